systolic_operand_feeder: RTL and testbench

- Producer side of the PE operand interface. Buffers matrix A (N x K) and matrix B (K x N), then drives skewed operand streams into the west (a) and north (b) edges of the N x N mac_unit array.
- Generates the array clear pulse before streaming and zero-fills the edges until the last product has settled.
- Signals completion so the result-readout logic can sample out_sum.

---
 rtl/systolic_operand_feeder_if.sv | 31 +++
 rtl/systolic_operand_feeder.sv | 107 ++++++++++
 tb/tb_systolic_operand_feeder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/systolic_operand_feeder_if.sv
// systolic_operand_feeder_if: load/start/stream bundle between the feeder and its controller/array.
//   master: drives load_en/load_sel/load_row/load_col/load_data/start, observes status and streams.
//   slave : the feeder; consumes loads/start, drives busy/done/array_clear/a_out/b_out.
interface systolic_operand_feeder_if #(
    parameter int DATA_SIZE = 8,
    parameter int N = 4,
    parameter int K = 4,
    parameter int IDX_W = $clog2((N > K) ? N : K)
);
    logic                   load_en;
    logic                   load_sel;
    logic [IDX_W-1:0]       load_row;
    logic [IDX_W-1:0]       load_col;
    logic [DATA_SIZE-1:0]   load_data;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   array_clear;
    logic [N*DATA_SIZE-1:0] a_out;
    logic [N*DATA_SIZE-1:0] b_out;

    modport master (
        output load_en, load_sel, load_row, load_col, load_data, start,
        input  busy, done, array_clear, a_out, b_out
    );

    modport slave (
        input  load_en, load_sel, load_row, load_col, load_data, start,
        output busy, done, array_clear, a_out, b_out
    );
endinterface

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: buffers A (NxK) and B (KxN) and streams them skewed into an NxN array.
//   clk, reset : clock, synchronous active-high reset.
//   bus.slave  : load port (IDLE only), start, busy/done/array_clear status, a_out/b_out edge lanes.
module systolic_operand_feeder #(
    parameter int DATA_SIZE = 8,
    parameter int N = 4,
    parameter int K = 4,
    parameter int IDX_W = $clog2((N > K) ? N : K)
) (
    input logic clk,
    input logic reset,
    systolic_operand_feeder_if.slave bus
);
    localparam int CW = $clog2(K + N);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_SIZE-1:0]   a_mem_q [N][K];
    logic [DATA_SIZE-1:0]   b_mem_q [K][N];
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   clr_q, clr_d;
    logic [N*DATA_SIZE-1:0] a_q, a_d;
    logic [N*DATA_SIZE-1:0] b_q, b_d;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.array_clear = clr_q;
    assign bus.a_out       = a_q;
    assign bus.b_out       = b_q;

    // Exact index matching makes out-of-range writes fall through untouched.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.load_en)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < K; k++) begin
                    if (!bus.load_sel && int'(bus.load_row) == i && int'(bus.load_col) == k)
                        a_mem_q[i][k] <= bus.load_data;
                    if (bus.load_sel && int'(bus.load_row) == k && int'(bus.load_col) == i)
                        b_mem_q[k][i] <= bus.load_data;
                end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (bus.start) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED:  if (cnt_q == CW'(K + N - 2)) begin
                state_d = FLUSH;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            FLUSH: if (cnt_q == CW'(N - 1)) begin
                state_d = DONE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they land in registers on the same edge.
    // Beat t feeds A[i][t-i] on row lane i and B[t-i][i] on column lane i.
    always_comb begin
        busy_d = state_d inside {CLEAR, FEED, FLUSH};
        done_d = state_d == DONE;
        clr_d  = state_d == CLEAR;
        a_d    = '0;
        b_d    = '0;
        if (state_d == FEED)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < K; k++)
                    if (int'(cnt_d) == i + k) begin
                        a_d[i*DATA_SIZE +: DATA_SIZE] = a_mem_q[i][k];
                        b_d[i*DATA_SIZE +: DATA_SIZE] = b_mem_q[k][i];
                    end
    end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb_systolic_operand_feeder: directed table-driven bench for the skewed operand feeder (N=K=4).
module tb_systolic_operand_feeder;
    localparam int ROWS = 15;

    typedef struct {
        logic        busy;
        logic        done;
        logic        clr;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [ROWS];

    always #5 clk = ~clk;

    systolic_operand_feeder_if #(.DATA_SIZE(8), .N(4), .K(4), .IDX_W(3)) bus ();

    systolic_operand_feeder #(.DATA_SIZE(8), .N(4), .K(4), .IDX_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input vec_t e);
        chk({nm, ".busy"}, 32'(bus.busy), 32'(e.busy));
        chk({nm, ".done"}, 32'(bus.done), 32'(e.done));
        chk({nm, ".clear"}, 32'(bus.array_clear), 32'(e.clr));
        chk({nm, ".a_out"}, bus.a_out, e.a);
        chk({nm, ".b_out"}, bus.b_out, e.b);
    endtask

    task automatic load(input bit sel, input int r, input int c, input logic [7:0] d);
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_sel  = sel;
        bus.load_row  = 3'(r);
        bus.load_col  = 3'(c);
        bus.load_data = d;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // Row r of the table is the state r cycles after start was presented.
    task automatic run_seq(input string nm, input bit disturb);
        @(negedge clk);
        bus.start = 1'b1;
        chk_all($sformatf("%s.c0", nm), tbl[0]);
        for (int r = 1; r < ROWS; r++) begin
            @(negedge clk);
            bus.start     = disturb && r == 5;
            bus.load_en   = disturb && (r == 3 || r == 4);
            bus.load_sel  = r == 4;
            bus.load_row  = 3'd0;
            bus.load_col  = 3'd0;
            bus.load_data = 8'hFF;
            chk_all($sformatf("%s.c%0d", nm, r), tbl[r]);
        end
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h00001001, 32'h00000110};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h00201102, 32'h00021120};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h30211203, 32'h03122130};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h31221300, 32'h13223100};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h32230000, 32'h23320000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h33000000, 32'h33000000};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000};

        reset         = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_sel  = 1'b0;
        bus.load_row  = '0;
        bus.load_col  = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", tbl[0]);
        reset = 1'b0;

        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                load(1'b0, i, k, 8'(16 * i + k));
                load(1'b1, i, k, 8'(16 * i + k));
            end

        // First run also tries loads and a second start while busy.
        run_seq("run1", 1'b1);
        // Out-of-range loads that would alias onto [0][0] if indices were truncated.
        load(1'b1, 4, 0, 8'hFF);
        load(1'b0, 0, 4, 8'hFF);
        load(1'b0, 4, 0, 8'hFF);
        run_seq("run2", 1'b0);

        // Load and start in the same IDLE cycle: the new value must be streamed.
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_sel  = 1'b0;
        bus.load_row  = 3'd3;
        bus.load_col  = 3'd3;
        bus.load_data = 8'h77;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        chk("same.clear", 32'(bus.array_clear), 32'd1);
        repeat (7) @(negedge clk);
        chk("same.a_beat6", bus.a_out, 32'h77000000);
        chk("same.b_beat6", bus.b_out, 32'h33000000);
        repeat (5) @(negedge clk);
        chk("same.done", 32'(bus.done), 32'd1);
        load(1'b0, 3, 3, 8'h33);

        // Reset at beat 3 aborts the run with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst.a_beat3", bus.a_out, 32'h30211203);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all("rst.after", tbl[0]);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk($sformatf("rst.nodone%0d", c), 32'({bus.done, bus.busy}), 32'd0);
        end
        run_seq("run3", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
